sisc: RTL and testbench

SISC -- requirements
Module: sisc

---
 rtl/sisc_pkg.sv | 38 +++
 rtl/sisc_alu.sv | 68 ++++++
 rtl/sisc.sv | 88 ++++++++
 tb/tb_sisc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcodes, ALU function codes, FSM states and status bit indices
package sisc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] FN_ADD  = 4'h1;
    localparam logic [3:0] FN_SUB  = 4'h2;
    localparam logic [3:0] FN_NOT  = 4'h4;
    localparam logic [3:0] FN_OR   = 4'h5;
    localparam logic [3:0] FN_AND  = 4'h6;
    localparam logic [3:0] FN_XOR  = 4'h7;
    localparam logic [3:0] FN_ROTR = 4'h8;
    localparam logic [3:0] FN_ROTL = 4'h9;
    localparam logic [3:0] FN_SHFR = 4'hA;
    localparam logic [3:0] FN_SHFL = 4'hB;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // Function codes 0, 3 and C-F are holes in the map and act as NOP.
    function automatic logic fn_defined(input logic [3:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || ((fn >= FN_NOT) && (fn <= FN_SHFL));
    endfunction

endpackage

// File: rtl/sisc_alu.sv
// rtl/sisc_alu.sv - combinational ALU producing a 32-bit result and {C,V,N,Z} flags
module sisc_alu
    import sisc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  fn,
    input  logic        imm_sel,
    input  logic [15:0] imm16,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic [31:0] opb;
    logic [3:0]  code;
    logic [4:0]  amt;
    logic [32:0] r33;
    logic [63:0] dbl;
    logic        ovf;

    always_comb begin
        opb    = imm_sel ? {16'h0000, imm16} : b;
        code   = imm_sel ? FN_ADD : fn;
        amt    = opb[4:0];
        r33    = 33'd0;
        dbl    = {a, a};
        ovf    = 1'b0;
        result = 32'd0;
        flags  = 4'd0;
        case (code)
            FN_ADD: begin
                r33 = {1'b0, a} + {1'b0, opb};
                ovf = (a[31] == opb[31]) && (r33[31] != a[31]);
            end
            FN_SUB: begin
                r33 = {1'b0, a} - {1'b0, opb};
                ovf = (a[31] != opb[31]) && (r33[31] != a[31]);
            end
            FN_NOT:  result = ~a;
            FN_OR:   result = a | opb;
            FN_AND:  result = a & opb;
            FN_XOR:  result = a ^ opb;
            FN_ROTR: begin
                dbl    = {a, a} >> amt;
                result = dbl[31:0];
            end
            FN_ROTL: begin
                dbl    = {a, a} << amt;
                result = dbl[63:32];
            end
            FN_SHFR: result = a >> amt;
            FN_SHFL: result = a << amt;
            default: result = 32'd0;
        endcase
        if ((code == FN_ADD) || (code == FN_SUB)) begin
            result         = r33[31:0];
            flags[STAT_C]  = r33[32];
            flags[STAT_V]  = ovf;
            // N reports the sign of the mathematically true result, not bit 31.
            flags[STAT_N]  = r33[31] ^ ovf;
            flags[STAT_Z]  = (r33[31:0] == 32'd0);
        end else begin
            flags[STAT_N]  = result[31];
            flags[STAT_Z]  = (result == 32'd0);
        end
    end

endmodule

// File: rtl/sisc.sv
// rtl/sisc.sv - multicycle processor top: five-state sequencer, register file, status register
module sisc
    import sisc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_F,
    input  logic [31:0] IR,
    output logic [3:0]  STAT,
    output logic        HALTED
);

    logic [31:0] regs [0:15];
    logic [31:0] ir_q;
    logic [3:0]  stat_q;
    state_t      state, next_state;

    logic [3:0]  op, rs, rt, rd, fn;
    logic [2:0]  mm_unused;
    logic        is_addi, wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] rs_val, rt_val, alu_result;
    logic [3:0]  alu_flags;

    assign op        = ir_q[31:28];
    assign mm_unused = ir_q[26:24];
    assign rs        = ir_q[23:20];
    assign rt        = ir_q[19:16];
    assign rd        = ir_q[15:12];
    assign fn        = ir_q[3:0];

    assign rs_val  = (rs == 4'd0) ? 32'd0 : regs[rs];
    assign rt_val  = (rt == 4'd0) ? 32'd0 : regs[rt];
    assign is_addi = (op == OP_ALU) && ir_q[27];
    assign wr_addr = is_addi ? rt : rd;
    assign wr_en   = (state == S_WRITEBACK) &&
                     (is_addi || ((op == OP_ALU) && !ir_q[27] && fn_defined(fn)));

    sisc_alu u_alu (
        .a       (rs_val),
        .b       (rt_val),
        .fn      (fn),
        .imm_sel (is_addi),
        .imm16   (ir_q[15:0]),
        .result  (alu_result),
        .flags   (alu_flags)
    );

    always_ff @(posedge CLK) begin
        if (RST_F) begin
            state  <= S_FETCH;
            ir_q   <= 32'd0;
            stat_q <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            state <= next_state;
            if (state == S_FETCH) begin
                ir_q <= IR;
            end
            // Operands stay stable for the whole instruction, so the ALU output
            // seen in WRITEBACK already reflects the previous instruction's writes.
            if (wr_en) begin
                stat_q <= alu_flags;
                if (wr_addr != 4'd0) begin
                    regs[wr_addr] <= alu_result;
                end
            end
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:     next_state = S_DECODE;
            S_DECODE:    next_state = (op == OP_HALT) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   next_state = S_MEM;
            S_MEM:       next_state = S_WRITEBACK;
            S_WRITEBACK: next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_FETCH;
        endcase
    end

    assign STAT   = stat_q;
    assign HALTED = (state == S_HALT);

endmodule

// File: tb/tb_sisc.sv
// tb/tb_sisc.sv - directed and randomized checks of sisc against an architectural model
module tb_sisc;

    logic        CLK;
    logic        RST_F;
    logic [31:0] IR;
    logic [3:0]  STAT;
    logic        HALTED;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_regs [16];
    logic [3:0]  m_stat;
    logic        m_halted;

    sisc dut (
        .CLK    (CLK),
        .RST_F  (RST_F),
        .IR     (IR),
        .STAT   (STAT),
        .HALTED (HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp)
        else begin
            tests_failed++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_stat   = 4'd0;
        m_halted = 1'b0;
    endtask

    // Architectural semantics written with integer arithmetic rather than bit tricks.
    task automatic model_exec(input logic [31:0] ins);
        logic [3:0]  op, rs, rt, rd, f, dst;
        logic [31:0] a, b, res;
        logic [63:0] u;
        longint      sa, sb, sum;
        int          n;
        logic        c, v, neg, arith;
        if (m_halted) return;
        op = ins[31:28]; rs = ins[23:20]; rt = ins[19:16]; rd = ins[15:12];
        if (op == 4'hF) begin
            m_halted = 1'b1;
            return;
        end
        if (op != 4'h8) return;
        a = m_regs[rs];
        if (ins[27]) begin
            b = {16'h0000, ins[15:0]}; f = 4'h1; dst = rt;
        end else begin
            b = m_regs[rt]; f = ins[3:0]; dst = rd;
        end
        n = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        arith = 1'b0; c = 1'b0; v = 1'b0; neg = 1'b0;
        case (f)
            4'h1: begin
                sum = sa + sb; u = {32'h0, a} + {32'h0, b};
                c = u[32]; arith = 1'b1;
            end
            4'h2: begin
                sum = sa - sb; c = (a < b); arith = 1'b1;
            end
            4'h4: res = ~a;
            4'h5: res = a | b;
            4'h6: res = a & b;
            4'h7: res = a ^ b;
            4'h8: res = (a >> n) | ((n == 0) ? 32'h0 : (a << (32 - n)));
            4'h9: res = (a << n) | ((n == 0) ? 32'h0 : (a >> (32 - n)));
            4'hA: res = a >> n;
            4'hB: res = a << n;
            default: return;
        endcase
        if (arith) begin
            v   = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
            neg = (sum < 0);
            res = sum[31:0];
            m_stat = {c, v, neg, (res == 32'd0)};
        end else begin
            m_stat = {2'b00, res[31], (res == 32'd0)};
        end
        if (dst != 4'd0) m_regs[dst] = res;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", tag, i), dut.regs[i], m_regs[i]);
        chk({tag, "_stat"}, {28'd0, STAT}, {28'd0, m_stat});
        chk({tag, "_halted"}, {31'd0, HALTED}, {31'd0, m_halted});
    endtask

    task automatic run_instr(input logic [31:0] ins, input string tag);
        logic [31:0] junk;
        @(negedge CLK) IR = ins;
        @(posedge CLK);
        #1 junk = $urandom;
        IR = junk;
        repeat (4) @(posedge CLK);
        #1;
        model_exec(ins);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK) RST_F = 1'b1;
        @(posedge CLK);
        #1 RST_F = 1'b0;
        model_reset();
        check_state(tag);
    endtask

    logic [31:0] seq26 [10] = '{32'h88010001, 32'h80112001, 32'h8022300B, 32'h80124002,
                                32'h8043400A, 32'h80342007, 32'h80202004, 32'h80214009,
                                32'h80245005, 32'h80243006};
    logic [31:0] exp26 [16] = '{32'h0, 32'h00000001, 32'hFF000008, 32'hFE000000,
                                32'hFE000011, 32'hFF000019, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] rnd;
    logic [3:0]  rop;
    logic [31:0] frozen [16];
    logic [3:0]  frozen_stat;

    initial begin
        RST_F = 1'b1;
        IR    = 32'd0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST_F = 1'b0;
        check_state("reset");

        for (int i = 0; i < 10; i++) run_instr(seq26[i], $sformatf("seq%0d", i));
        for (int i = 0; i < 16; i++) chk($sformatf("arith_r%0d", i), dut.regs[i], exp26[i]);

        run_instr(32'h88010001, "st0");
        chk("st0_lit", {28'd0, STAT}, 32'h0);
        run_instr(32'h80112002, "st1");
        chk("st1_lit", {28'd0, STAT}, 32'h1);
        run_instr(32'h80012002, "st2");
        chk("st2_r2", dut.regs[2], 32'hFFFFFFFF);
        chk("st2_lit", {28'd0, STAT}, 32'hA);
        run_instr(32'h80113008, "st3");
        chk("st3_r3", dut.regs[3], 32'h80000000);
        run_instr(32'h80234001, "st4");
        chk("st4_r4", dut.regs[4], 32'h7FFFFFFF);
        chk("st4_lit", {28'd0, STAT}, 32'hE);

        run_instr(32'h88000005, "r0w");
        run_instr(32'h80001001, "r0add");
        chk("r0_lit", dut.regs[0], 32'h0);
        chk("r1_lit", dut.regs[1], 32'h0);

        for (int k = 0; k < 60; k++) begin
            rnd = $urandom;
            case ($urandom_range(0, 9))
                7:       rop = 4'h0;
                8:       rop = 4'h3;
                9:       rop = 4'hC;
                default: rop = 4'h8;
            endcase
            run_instr({rop, rnd[27:0]}, $sformatf("rnd%0d", k));
        end

        @(negedge CLK) IR = 32'h88010005;
        @(posedge CLK);
        #1 IR = 32'h0;
        @(posedge CLK);
        @(negedge CLK) RST_F = 1'b1;
        @(posedge CLK);
        #1 RST_F = 1'b0;
        model_reset();
        check_state("midrst");
        run_instr(32'h88010005, "after_midrst");
        chk("after_midrst_lit", dut.regs[1], 32'h5);

        run_instr(32'h88020007, "pre_halt");
        for (int i = 0; i < 16; i++) frozen[i] = m_regs[i];
        frozen_stat = m_stat;
        run_instr(32'hF0000000, "halt");
        run_instr(32'h80221001, "halt_add");
        run_instr(32'h88031234, "halt_addi");
        chk("halt_lit", {31'd0, HALTED}, 32'h1);
        for (int i = 0; i < 16; i++) chk($sformatf("frozen_r%0d", i), dut.regs[i], frozen[i]);
        chk("frozen_stat", {28'd0, STAT}, {28'd0, frozen_stat});

        do_reset("halt_rst");
        chk("unhalt_lit", {31'd0, HALTED}, 32'h0);
        run_instr(32'h88040009, "post_halt");
        chk("post_halt_lit", dut.regs[4], 32'h9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
